// File: rtl/trace_recorder_if.sv
`default_nettype none
// ============================================================================
// trace_recorder_if
//   CPU trace inputs and serial record output stream of the trace recorder.
//   Revision: 1.0
// ============================================================================
interface trace_recorder_if;
  logic       enable;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] x;
  logic [7:0] q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic [7:0] dropped;

  // master: the recorder itself; slave: the CPU/consumer environment
  modport master (
    input  enable, pc, ir, a, b, x, q, out_ready,
    output out_data, out_valid, overflow, dropped
  );

  modport slave (
    output enable, pc, ir, a, b, x, q, out_ready,
    input  out_data, out_valid, overflow, dropped
  );
endinterface
`default_nettype wire

// File: rtl/trace_recorder.sv
`default_nettype none
// ============================================================================
// trace_recorder
//   Captures {pc,ir,a,b,x,q} on register change, buffers in a FIFO and
//   streams each 48-bit record out as six bytes.
//   Revision: 1.0
// ============================================================================
module trace_recorder #(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  trace_recorder_if.master      bus
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   c_full = DEPTH[AW:0];

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [47:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_first;
  logic [31:0]   r_last;
  state_t        r_state;
  logic [2:0]    r_idx;
  logic [47:0]   r_rec;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_overflow;
  logic [7:0]    r_dropped;

  logic [31:0]   w_regs;
  logic          w_capture;
  logic          w_last_acc;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [47:0]   w_head;
  logic [5:0]    w_shamt;
  logic [47:0]   w_rec_shift;
  logic [7:0]    w_next_byte;

  assign w_regs      = {bus.a, bus.b, bus.x, bus.q};
  assign w_capture   = bus.enable && (r_first || (w_regs != r_last));
  assign w_last_acc  = (r_state == SEND) && bus.out_ready && (r_idx == 3'd5);
  assign w_pop       = ((r_state == IDLE) || w_last_acc) && (r_count != '0);
  // A full FIFO still accepts when its head leaves at the same edge
  assign w_push      = w_capture && ((r_count != c_full) || w_pop);
  assign w_drop      = w_capture && !w_push;
  assign w_head      = r_mem[r_rd_ptr];

  assign w_shamt     = {3'(r_idx + 3'd1), 3'b000};
  assign w_rec_shift = r_rec << w_shamt;
  assign w_next_byte = w_rec_shift[47:40];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.pc, bus.ir, w_regs};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Dropped captures still refresh the change-detect reference
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first    <= 1'b1;
      r_last     <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else begin
      if (w_capture) begin
        r_first <= 1'b0;
        r_last  <= w_regs;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != 8'hFF) begin
          r_dropped <= r_dropped + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_rec       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_state     <= SEND;
      r_idx       <= '0;
      r_rec       <= w_head;
      r_out_data  <= w_head[47:40];
      r_out_valid <= 1'b1;
    end else if ((r_state == SEND) && bus.out_ready) begin
      if (r_idx == 3'd5) begin
        r_state     <= IDLE;
        r_idx       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_idx      <= r_idx + 3'd1;
        r_out_data <= w_next_byte;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.overflow  = r_overflow;
  assign bus.dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_trace_recorder.sv
`default_nettype none
// ============================================================================
// tb_trace_recorder
//   Directed scenarios plus random traffic against a queue-based model.
//   Revision: 1.0
// ============================================================================
module tb_trace_recorder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trace_recorder_if bus();

  trace_recorder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Model: records waiting, bytes of the record being sent, change reference
  logic [47:0] m_fifo[$];
  logic [7:0]  m_cur[$];
  bit          m_first;
  logic [31:0] m_last;
  bit          m_ovf;
  int          m_drop;

  task automatic m_reset();
    m_fifo.delete();
    m_cur.delete();
    m_first = 1;
    m_last  = '0;
    m_ovf   = 0;
    m_drop  = 0;
  endtask

  task automatic m_edge();
    logic [47:0] rec;
    logic [31:0] regs;
    bit can_take;
    can_take = 0;
    if (m_cur.size() == 0) can_take = 1;
    else if (bus.out_ready) begin
      void'(m_cur.pop_front());
      can_take = (m_cur.size() == 0);
    end
    if (can_take && m_fifo.size() > 0) begin
      rec = m_fifo.pop_front();
      for (int k = 0; k < 6; k++) m_cur.push_back(rec[47-8*k -: 8]);
    end
    regs = {bus.a, bus.b, bus.x, bus.q};
    if (bus.enable && (m_first || regs != m_last)) begin
      m_first = 0;
      m_last  = regs;
      if (m_fifo.size() < DEPTH) m_fifo.push_back({bus.pc, bus.ir, regs});
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", bus.out_valid, m_cur.size() != 0);
    if (m_cur.size() != 0) chk("out_data", bus.out_data, m_cur[0]);
    chk("overflow", bus.overflow, m_ovf);
    chk("dropped", bus.dropped, m_drop);
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    #1;
    compare();
  endtask

  task automatic set_regs(input logic [7:0] pc, ir, a, b, x, q);
    bus.pc = pc; bus.ir = ir; bus.a = a; bus.b = b; bus.x = x; bus.q = q;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_drop", bus.dropped, 0);
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_valid", bus.out_valid, 0);
    #1;
    reset = 1'b0;
  endtask

  int nb;
  int guard;

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.out_ready = 1'b0;
    set_regs(0, 0, 0, 0, 0, 0);
    #1;
    do_reset();

    // first capture: exactly six bytes, then silence
    bus.enable = 1'b1; bus.out_ready = 1'b1;
    set_regs(10, 20, 1, 2, 3, 4);
    nb = 0;
    repeat (20) begin cyc(); if (bus.out_valid) nb++; end
    chk("first_nbytes", nb, 6);

    // change detect: pc alone never triggers
    do_reset();
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      bus.pc = 8'(i);
      cyc();
      if (bus.out_valid) nb++;
    end
    bus.a = 8'd5;
    repeat (15) begin cyc(); if (bus.out_valid) nb++; end
    chk("chg_nbytes", nb, 12);

    // backpressure
    do_reset();
    bus.out_ready = 1'b0;
    set_regs(8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    repeat (10) cyc();
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_data", bus.out_data, 8'h5A);
    bus.out_ready = 1'b1;
    nb = 0;
    repeat (10) begin if (bus.out_valid) nb++; cyc(); end
    chk("bp_nbytes", nb, 6);

    // overflow and saturation
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.a = 8'(i + 1);
      cyc();
      if (i == 11) begin
        chk("ovf12_drop", bus.dropped, 3);
        chk("ovf12_flag", bus.overflow, 1);
      end
    end
    chk("drop_sat", bus.dropped, 255);

    // full FIFO with push at the same edge as the last-byte pop
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin bus.a = 8'(i + 1); cyc(); end
    chk("full_drop0", bus.dropped, 0);
    bus.out_ready = 1'b1;
    repeat (5) cyc();
    bus.a = 8'hEE;
    cyc();
    chk("fullpop_drop", bus.dropped, 0);
    chk("fullpop_ovf", bus.overflow, 0);
    repeat (70) cyc();

    // reset after byte index 2 accepted
    do_reset();
    set_regs(8'h77, 8'h66, 8'h01, 8'h02, 8'h03, 8'h04);
    guard = 0;
    while (m_cur.size() != 3 && guard < 20) begin cyc(); guard++; end
    chk("mid_reached", guard < 20, 1);
    do_reset();
    cyc();
    cyc();
    chk("restart_valid", bus.out_valid, 1);
    chk("restart_byte0", bus.out_data, 8'h77);
    repeat (8) cyc();

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0) && (i % 400 > 60);
      bus.pc = 8'($urandom);
      bus.ir = 8'($urandom);
      case ($urandom_range(0, 5))
        0: bus.a = 8'($urandom_range(0, 3));
        1: bus.b = 8'($urandom_range(0, 3));
        2: bus.x = 8'($urandom_range(0, 3));
        3: bus.q = 8'($urandom_range(0, 3));
        default: ;
      endcase
      if ($urandom_range(0, 699) == 0) do_reset();
      else cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
